node_out_window_counter: RTL

Downstream consumer of a node's 1-bit `out`. It samples `out` every clock over fixed windows of WINDOW cycles. Per window it counts qualified ones and output transitions, then presents the result with a valid/ready handshake to a readback or logging stage. Windows run back-to-back with no gap until stopped.

---
 rtl/node_out_window_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/node_out_window_counter.sv
// Samples a node's 1-bit output over back-to-back windows of WINDOW cycles.
// Each window produces a count of qualified ones and transitions, handed off via valid/ready.
module node_out_window_counter #(
  parameter int unsigned WINDOW = 40,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned IDX_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             node_out,
  input  logic             high,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [IDX_W-1:0] win_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CYC_W = $clog2(WINDOW);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [CYC_W-1:0]   cyc;
  logic [CNT_W-1:0]   ones_acc, edge_acc;
  logic [IDX_W-1:0]   win_cnt;
  logic               prev;

  logic               sample_c, last_c, consume_c;
  logic [CNT_W-1:0]   ones_sum_c, edge_sum_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: stop wins over everything in RUN, start only matters in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first sample of a window never counts an edge, so windows stay independent
  always_comb begin
    sample_c   = (state == RUN) && !stop;
    last_c     = sample_c && (cyc == CYC_W'(WINDOW - 1));
    consume_c  = res_valid && res_ready;
    ones_sum_c = ones_acc + CNT_W'(node_out & high);
    edge_sum_c = edge_acc + CNT_W'((cyc != '0) && (node_out != prev));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cyc       <= '0;
      ones_acc  <= '0;
      edge_acc  <= '0;
      win_cnt   <= '0;
      prev      <= 1'b0;
      ones_cnt  <= '0;
      edge_cnt  <= '0;
      win_idx   <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy <= (state_next == RUN);

      if ((state == IDLE) && start) begin
        cyc      <= '0;
        ones_acc <= '0;
        edge_acc <= '0;
        win_cnt  <= '0;
        overrun  <= 1'b0;
      end else if (sample_c) begin
        prev <= node_out;
        if (last_c) begin
          cyc      <= '0;
          ones_acc <= '0;
          edge_acc <= '0;
          win_cnt  <= win_cnt + IDX_W'(1);
        end else begin
          cyc      <= cyc + CYC_W'(1);
          ones_acc <= ones_sum_c;
          edge_acc <= edge_sum_c;
        end
      end

      // A held, unconsumed result is never overwritten; the new one is dropped
      if (last_c) begin
        if (!res_valid || consume_c) begin
          ones_cnt  <= ones_sum_c;
          edge_cnt  <= edge_sum_c;
          win_idx   <= win_cnt;
          res_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (consume_c) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
